// File: rtl/ram32x4_reader_pkg.sv
// ram32x4_reader_pkg: shared types and default sizing for the 32x4 RAM read sequencer.
package ram32x4_reader_pkg;

  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned DATA_W_DEF   = 4;
  localparam int unsigned TICK_DIV_DEF = 50_000_000;
  localparam int unsigned RD_LAT_DEF   = 1;

  // Fetch sequence: present address, let the RAM settle, latch the word, then dwell.
  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } rd_state_e;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram32x4_reader_tick.sv
// tick_divider: free-running divide-by-TICK_DIV counter used as the auto-advance timebase.
// tc is high in the cycle the count sits at TICK_DIV-1 while enabled.
module tick_divider
  import ram32x4_reader_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tc
);

  localparam int unsigned      CNT_W = cnt_width(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 32'd1);

  logic [CNT_W-1:0] r_cnt;

  // Count while enabled, wrap at the terminal value; clear discards any progress.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign tc = enable && (r_cnt == LAST);

endmodule

// File: rtl/ram32x4_reader.sv
// ram32x4_reader: sweeps a 2^ADDR_W x DATA_W synchronous RAM and presents each word with its
// address. Advances automatically on a divided tick (run=1) or on single step pulses (run=0).
// Optional feature macro: RAM32X4_READER_CHECKSUM_EN adds a per-sweep modulo-2^DATA_W checksum;
// without it the checksum port is tied to 0.
module ram32x4_reader
  import ram32x4_reader_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned RD_LAT   = RD_LAT_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [DATA_W-1:0] cur_data,
  output logic              data_valid,
  output logic              sweep_done,
  output logic [DATA_W-1:0] checksum
);

  localparam int unsigned       WAIT_W    = cnt_width(RD_LAT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 32'd1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

  rd_state_e         r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [DATA_W-1:0] r_cur_data;
  logic              r_data_valid;

  logic w_in_hold;
  logic w_tick_en;
  logic w_tc;
  logic w_advance;
  logic w_wrap;

  // The tick only runs while dwelling in auto mode; anything else restarts it from zero.
  assign w_in_hold = (r_state == HOLD);
  assign w_tick_en = w_in_hold && run;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (w_tick_en),
    .clear    (!w_tick_en),
    .tc       (w_tc)
  );

  // An advance is only honoured in HOLD, so early or held step pulses are dropped, never queued.
  assign w_advance = w_in_hold && (run ? w_tc : step);
  assign w_wrap    = w_advance && (r_ram_addr == ADDR_MAX);

  // Fetch sequencer: address is held from ISSUE through HOLD and moves only on an advance.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= ISSUE;
      r_wait_cnt   <= '0;
      r_ram_addr   <= '0;
      r_cur_addr   <= '0;
      r_cur_data   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      case (r_state)
        ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_state <= CAPTURE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          r_cur_data   <= ram_q;
          r_cur_addr   <= r_ram_addr;
          r_data_valid <= 1'b1;
          r_state      <= HOLD;
        end
        HOLD: begin
          if (w_advance) begin
            r_ram_addr   <= r_ram_addr + 1'b1;
            r_data_valid <= 1'b0;
            r_state      <= ISSUE;
          end else begin
            r_state <= HOLD;
          end
        end
        default: begin
          r_state <= ISSUE;
        end
      endcase
    end
  end

`ifdef RAM32X4_READER_CHECKSUM_EN
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_checksum;

  // Sum each word as it is captured; on wrap publish the sum (last word included) and restart.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_checksum <= '0;
    end else if (r_state == CAPTURE) begin
      r_acc <= r_acc + ram_q;
    end else if (w_wrap) begin
      r_checksum <= r_acc;
      r_acc      <= '0;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign ram_addr   = r_ram_addr;
  assign ram_wren   = 1'b0;
  assign cur_addr   = r_cur_addr;
  assign cur_data   = r_cur_data;
  assign data_valid = r_data_valid;
  // Wrap pulse is asserted in the cycle whose closing edge returns ram_addr to 0.
  assign sweep_done = w_wrap;

endmodule

// File: doc/ram32x4_reader.md
# ram32x4_reader

Autonomous read-side sequencer for the 32x4 synchronous RAM. It sweeps addresses 0..31 and presents each stored word, with its address, to the HEX decoders. Advance is automatic on a divided tick, or manual one step at a time. It sits beside the switch-driven write path. When the reader owns the RAM port, the top level muxes the reader's ram_addr and ram_wren onto the RAM.

## Interface
- ADDR_W, 5, RAM address width; sweep length is 2^ADDR_W.
- DATA_W, 4, RAM word width.
- TICK_DIV, 50_000_000, CLOCK_50 cycles per automatic advance; minimum 2.
- RD_LAT, 1, RAM read latency in cycles (1 = registered address, 2 = registered address and q); minimum 1.

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- run  in  1  level; 1 = auto-advance on tick, 0 = manual.
- step  in  1  single-cycle pulse (synchronised upstream); advances one address when run=0.
- ram_addr  out  ADDR_W  read address to RAM.
- ram_wren  out  1  constant 0; the reader never writes.
- ram_q  in  DATA_W  RAM read data.
- cur_addr  out  ADDR_W  address of the word in cur_data.
- cur_data  out  DATA_W  last captured word.
- data_valid  out  1  cur_data/cur_addr are consistent with the RAM.
- sweep_done  out  1  one-cycle pulse when the address wraps from 2^ADDR_W-1 to 0.
- checksum  out  DATA_W  sweep checksum (see Configuration).

## Operation
- The FSM has four states:
  - ISSUE: ram_addr is stable. Always go to WAIT.
  - WAIT: count RD_LAT cycles, then go to CAPTURE.
  - CAPTURE: cur_data<=ram_q, cur_addr<=ram_addr, data_valid<=1. Always go to HOLD.
  - HOLD: wait for an advance event.
- Advance event:
  - run=1: the tick counter reaches TICK_DIV-1.
  - run=0: step=1 in HOLD.
- On advance: ram_addr<=ram_addr+1 modulo 2^ADDR_W, data_valid<=0, next state ISSUE.
- If the old address was 2^ADDR_W-1, sweep_done=1 for that cycle.
- Tick counter:
  - Counts only in HOLD with run=1.
  - Cleared on entering HOLD and whenever run=0.
  - Dropping run mid-count discards the progress.
- step is ignored when run=1 and outside HOLD. It is never queued.
- A run change during ISSUE, WAIT or CAPTURE takes effect in HOLD only.
- ram_addr changes only on the advance edge. It is constant across ISSUE..HOLD.

## Timing
- Reset values:
  - ram_addr=0, cur_addr=0, cur_data=0, checksum=0.
  - data_valid=0, sweep_done=0, ram_wren=0.
  - state=ISSUE, tick and wait counters 0.
- After reset deasserts, ISSUE occupies cycle 0. WAIT occupies cycles 1..RD_LAT. CAPTURE is at cycle RD_LAT+1. data_valid is seen high from cycle RD_LAT+2.
- Advance-to-valid latency is RD_LAT+2 cycles.
- Automatic period: TICK_DIV cycles in HOLD, plus RD_LAT+2 cycles of fetch. A full sweep takes 32*(TICK_DIV+RD_LAT+2) cycles.
- Minimum manual step spacing is RD_LAT+3 cycles. Earlier steps are dropped.
- Reset mid-fetch aborts the fetch and restarts at address 0. No sweep_done is emitted.
- sweep_done coincides with the cycle in which ram_addr becomes 0 on the next edge.

## Configuration
- RAM32X4_READER_CHECKSUM_EN defined:
  - The accumulator adds cur_data modulo 2^DATA_W at each CAPTURE.
  - On wrap, checksum<=the accumulator, which includes word 2^ADDR_W-1, and the accumulator is cleared.
  - checksum holds its value between wraps. It is reset to 0.
- Macro undefined:
  - The accumulator is removed.
  - checksum is tied to 0, so the port list is identical for both builds.

## Structure
- Package ram32x4_reader_pkg holds:
  - the state enum (ISSUE, WAIT, CAPTURE, HOLD);
  - default ADDR_W and DATA_W constants;
  - TICK_DIV's default.
- Sub-module tick_divider has inputs CLOCK_50, reset, enable and clear, and output tc. It is instantiated once and enabled by (state==HOLD && run).
- The wait counter and FSM live in the top module.

## Test plan
- Reset with RAM preloaded with word[i]=i mod 16, RD_LAT=1 -> cur_addr=0, cur_data=0 and data_valid=1 at cycle 3. ram_wren stays 0.
- run=0, eight step pulses spaced 10 cycles apart -> cur_addr steps 1..8 with cur_data 1..8. Each value is valid 3 cycles after its step.
- run=1, TICK_DIV=4 -> a new address every 7 cycles. After the address reaches 31, sweep_done pulses once and cur_addr returns to 0.
- Checksum build with word[i]=i mod 16 over a full sweep -> checksum=0, since 2*(0+..+15)=240, and 240 mod 16=0. With word 5 changed to 9, checksum=4.
- step pulses 1 cycle apart, and step held high with run=1 -> extra steps are dropped and no address is skipped.
- Reset asserted in WAIT at address 17 -> outputs are 0 immediately. The fetch restarts at address 0 and no sweep_done pulse occurs.
